led_fader: RTL

- Downstream consumer of the LED blinker's toggling output.
- Turns each hard on/off edge into a linear brightness ramp, then drives the physical LED pin with a PWM waveform.
- Configured through an Avalon-MM slave on the same clock domain as the blinker.

---
 rtl/led_fader_pkg.sv | 20 ++
 rtl/led_fader_pwm.sv | 30 +++
 rtl/led_fader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_fader_pkg.sv
// Shared types and constants for the LED fader: ramp state encoding,
// Avalon-MM word addresses and CTRL register bit positions.
package led_fader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } fade_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_MAX    = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;

endpackage

// File: rtl/led_fader_pwm.sv
// Free-running PWM generator: registered compare of a wrapping counter
// against duty, with an optional output inversion applied after the register.
module led_fader_pwm #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PWM_W-1:0] duty,
    input  logic             invert,
    output logic             pwm_out
);

    logic [PWM_W-1:0] r_pwm_cnt;
    logic             r_pwm_raw;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
            r_pwm_raw <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_pwm_raw <= (r_pwm_cnt < duty);
        end
    end

    assign pwm_out = r_pwm_raw ^ invert;

endmodule

// File: rtl/led_fader.sv
// led_fader: turns blinker edges into linear brightness ramps and drives a PWM LED pin.
// Define LED_FADER_GAMMA_EN to map level to duty through a square-law curve.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_W = 8,
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        blink_in,
    output logic        pwm_out
);

    logic              r_en;
    logic              r_inv;
    logic [PWM_W-1:0]  r_max_level;
    logic [DIV_W-1:0]  r_step_div;
    logic [DIV_W-1:0]  r_step_cnt;
    logic              r_blink_q;
    fade_state_t       r_state;
    logic [PWM_W-1:0]  r_level;
    logic [31:0]       r_readdata;

    logic              w_rise;
    logic              w_fall;
    logic              w_tick;
    fade_state_t       w_next_state;
    logic [PWM_W-1:0]  w_next_level;
    logic [31:0]       w_read_mux;
    logic [PWM_W-1:0]  w_duty;
    logic              w_unused;

    assign w_rise   = blink_in & ~r_blink_q;
    assign w_fall   = ~blink_in & r_blink_q;
    assign w_tick   = (r_step_cnt == r_step_div);
    assign readdata = r_readdata;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        w_read_mux = '0;
        case (address)
            ADDR_CTRL: begin
                w_read_mux[CTRL_EN_BIT]  = r_en;
                w_read_mux[CTRL_INV_BIT] = r_inv;
            end
            ADDR_MAX:    w_read_mux[PWM_W-1:0] = r_max_level;
            ADDR_DIV:    w_read_mux[DIV_W-1:0] = r_step_div;
            ADDR_STATUS: begin
                w_read_mux[1:0]        = r_state;
                w_read_mux[8 +: PWM_W] = r_level;
            end
            default: ;
        endcase
    end

    // A write wins over a simultaneous read; readdata then keeps its old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en        <= 1'b0;
            r_inv       <= 1'b0;
            r_max_level <= '1;
            r_step_div  <= '0;
            r_readdata  <= '0;
        end else if (write) begin
            case (address)
                ADDR_CTRL: begin
                    r_en  <= writedata[CTRL_EN_BIT];
                    r_inv <= writedata[CTRL_INV_BIT];
                end
                ADDR_MAX: r_max_level <= writedata[PWM_W-1:0];
                ADDR_DIV: r_step_div  <= writedata[DIV_W-1:0];
                default: ;
            endcase
        end else if (read) begin
            r_readdata <= w_read_mux;
        end
    end

    // Edges take precedence over step ticks; the final clamp handles MAX_LEVEL
    // being lowered underneath the current level in any state.
    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        if (!r_en) begin
            w_next_state = ST_IDLE;
            w_next_level = '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rise) w_next_state = ST_UP;
                ST_UP: begin
                    if (w_fall) begin
                        w_next_state = ST_DOWN;
                    end else if (r_level >= r_max_level) begin
                        w_next_state = ST_ON;
                        w_next_level = r_max_level;
                    end else if (w_tick) begin
                        w_next_level = r_level + 1'b1;
                        if (w_next_level == r_max_level) w_next_state = ST_ON;
                    end
                end
                ST_ON: if (w_fall) w_next_state = ST_DOWN;
                ST_DOWN: begin
                    if (w_rise) begin
                        w_next_state = ST_UP;
                    end else if (r_level == '0) begin
                        w_next_state = ST_IDLE;
                    end else if (w_tick) begin
                        w_next_level = r_level - 1'b1;
                        if (r_level == PWM_W'(1)) w_next_state = ST_IDLE;
                    end
                end
                default: ;
            endcase
            if (w_next_level > r_max_level) w_next_level = r_max_level;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_level    <= '0;
            r_step_cnt <= '0;
            r_blink_q  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_level   <= w_next_level;
            r_blink_q <= blink_in;
            if (w_next_state != r_state || w_tick) r_step_cnt <= '0;
            else                                   r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_W-1:0] w_level_ext;
    logic [2*PWM_W-1:0] w_level_sq;
    assign w_level_ext = {{PWM_W{1'b0}}, r_level};
    assign w_level_sq  = w_level_ext * w_level_ext;
    assign w_duty      = w_level_sq[2*PWM_W-1:PWM_W];
    assign w_unused    = ^{writedata[31:DIV_W], w_level_sq[PWM_W-1:0]};
`else
    assign w_duty      = r_level;
    assign w_unused    = ^writedata[31:DIV_W];
`endif

    led_fader_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .duty    (w_duty),
        .invert  (r_inv),
        .pwm_out (pwm_out)
    );

endmodule
